// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared FSM encoding, init-table entry layout and default table
package spi_seq_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_NEXT      = 3'd4;
  localparam logic [2:0] ST_POLL_GAP  = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERROR     = 3'd7;
  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_ACK  = ST_WAIT_ACK,
    WAIT_DONE = ST_WAIT_DONE,
    NEXT      = ST_NEXT,
    POLL_GAP  = ST_POLL_GAP,
    DONE      = ST_DONE,
    ERROR     = ST_ERROR
  } state_t;
  localparam int ENTRY_WRITE_BIT = 15;
  localparam int ENTRY_ADDR_MSB  = 14;
  localparam int ENTRY_ADDR_LSB  = 8;
  localparam int ENTRY_DATA_MSB  = 7;
  localparam int ENTRY_DATA_LSB  = 0;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Default table: {write, address, data}; unlisted slots read back as zero
  function automatic logic [15:0] init_entry(input logic [5:0] idx);
    case (idx)
      6'd0:    return 16'h90A5;
      6'd1:    return 16'h913C;
      6'd2:    return 16'h1200;
      6'd3:    return 16'h8301;
      6'd4:    return 16'h8402;
      6'd5:    return 16'h0500;
      6'd6:    return 16'h8680;
      6'd7:    return 16'h0700;
      default: return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/spi_init_rom.sv
// spi_init_rom: combinational lookup of the init table entry at index
module spi_init_rom
  import spi_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int IW = idx_w(NUM_ENTRIES)
) (
  input  logic [IW-1:0] index,
  output logic [15:0]   entry
);
  assign entry = init_entry(6'(index));
endmodule

// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer: walks the init table through spi_master, then polls a status byte
module spi_init_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         NUM_ENTRIES   = 8,
  parameter logic [6:0] POLL_ADDR     = 7'h00,
  parameter logic [7:0] POLL_MASK     = 8'h01,
  parameter logic [7:0] POLL_VALUE    = 8'h01,
  parameter int         POLL_INTERVAL = 1024,
  parameter int         MAX_POLLS     = 16,
  parameter int         ACK_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       error,
  output logic [7:0] last_read,
  output logic       spi_write,
  output logic [6:0] spi_address,
  output logic [7:0] spi_data_in,
  output logic       spi_strobe,
  input  logic       spi_busy,
  input  logic       spi_read_data_valid,
  input  logic [7:0] spi_data_out
);
  localparam int IW = idx_w(NUM_ENTRIES);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t        state;
  logic [IW-1:0] index;
  logic          poll_phase;
  logic [PW-1:0] poll_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] ack_cnt;
  logic [15:0]   entry;
  spi_init_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (.index(index), .entry(entry));
  // Sequencer FSM: issues one transfer at a time, then polls until match or budget spent
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      poll_phase  <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      ack_cnt     <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      last_read   <= '0;
      spi_write   <= 1'b0;
      spi_address <= '0;
      spi_data_in <= '0;
      spi_strobe  <= 1'b0;
    end else begin
      spi_strobe <= 1'b0;
      case (state)
        IDLE, DONE, ERROR:
          if (start) begin
            done       <= 1'b0;
            error      <= 1'b0;
            index      <= '0;
            poll_cnt   <= '0;
            poll_phase <= 1'b0;
            state      <= ISSUE;
          end
        ISSUE:
          if (!spi_busy) begin
            spi_write   <= poll_phase ? 1'b0 : entry[ENTRY_WRITE_BIT];
            spi_address <= poll_phase ? POLL_ADDR : entry[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
            spi_data_in <= poll_phase ? 8'h00 : entry[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
            spi_strobe  <= 1'b1;
            ack_cnt     <= '0;
            state       <= WAIT_ACK;
          end
        WAIT_ACK:
          if (spi_busy) state <= WAIT_DONE;
          else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= ERROR;
          end else ack_cnt <= ack_cnt + TW'(1);
        WAIT_DONE: begin
          if (spi_read_data_valid && !spi_write) last_read <= spi_data_out;
          if (!spi_busy) state <= NEXT;
        end
        NEXT:
          if (!poll_phase) begin
            if (index == IW'(NUM_ENTRIES - 1)) poll_phase <= 1'b1;
            else index <= index + IW'(1);
            state <= ISSUE;
          end else if ((last_read & POLL_MASK) == POLL_VALUE) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
            if (poll_cnt + PW'(1) == PW'(MAX_POLLS)) begin
              error <= 1'b1;
              state <= ERROR;
            end else begin
              gap_cnt <= '0;
              state   <= POLL_GAP;
            end
          end
        POLL_GAP:
          if (gap_cnt == GW'(POLL_INTERVAL - 1)) state <= ISSUE;
          else gap_cnt <= gap_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_init_sequencer.sv
// tb_spi_init_sequencer: scoreboard bench with a behavioural spi_master model
module tb_spi_init_sequencer;
  localparam int         NE    = 3;
  localparam logic [6:0] PADDR = 7'h00;
  localparam int         PI    = 20;
  localparam int         MP    = 4;
  localparam int         AT    = 8;
  localparam int         BUSY_LEN = 40;
  // strobe -> busy (1) + busy (40) + fall seen (1) + NEXT (1) + gap (PI) + ISSUE (1)
  localparam int         POLL_PERIOD = 1 + BUSY_LEN + 1 + 1 + PI + 1;
  logic clk = 1'b0;
  logic rst_n, start;
  logic done, error, spi_write, spi_strobe, spi_busy, spi_read_data_valid;
  logic [7:0] last_read, spi_data_in, spi_data_out;
  logic [6:0] spi_address;
  logic no_ack, force_busy, is_rd, prev_strobe;
  logic [7:0] rd_val;
  int bcnt;
  int total = 0, bad = 0, cyc = 0;
  int n_strobe = 0, n_poll = 0, last_strobe_cyc = 0, last_poll_cyc = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  poll_q[$];
  spi_init_sequencer #(
    .NUM_ENTRIES(NE), .POLL_ADDR(PADDR), .POLL_MASK(8'h01), .POLL_VALUE(8'h01),
    .POLL_INTERVAL(PI), .MAX_POLLS(MP), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error),
    .last_read(last_read), .spi_write(spi_write), .spi_address(spi_address),
    .spi_data_in(spi_data_in), .spi_strobe(spi_strobe), .spi_busy(spi_busy),
    .spi_read_data_valid(spi_read_data_valid), .spi_data_out(spi_data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // spi_master model: busy one cycle after strobe, held BUSY_LEN cycles, read data on last busy cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcnt <= 0;
      is_rd <= 1'b0;
      rd_val <= 8'h00;
      spi_read_data_valid <= 1'b0;
      spi_data_out <= 8'h00;
    end else begin
      spi_read_data_valid <= 1'b0;
      if (spi_strobe && !no_ack) begin
        bcnt <= BUSY_LEN;
        is_rd <= !spi_write;
        if (!spi_write && spi_address == 7'h12) rd_val <= 8'h5A;
        else if (!spi_write && spi_address == PADDR && poll_q.size() != 0) rd_val <= poll_q.pop_front();
        else rd_val <= 8'h00;
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 2 && is_rd) begin
          spi_read_data_valid <= 1'b1;
          spi_data_out <= rd_val;
        end
      end
    end
  assign spi_busy = (bcnt != 0) || force_busy;
  always @(negedge clk) prev_strobe <= spi_strobe;
  // Strobe monitor: pops the scoreboard and times poll reads
  always @(negedge clk)
    if (rst_n && spi_strobe) begin
      chk("strobe_pulse", 32'(prev_strobe), 0);
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'(exp_q.size()), 1);
      else chk("strobe_fields", {spi_write, spi_address, spi_data_in}, exp_q.pop_front());
      if (!spi_write && spi_address == PADDR) begin
        if (n_poll > 0) chk("poll_gap", cyc - last_poll_cyc, POLL_PERIOD);
        n_poll++;
        last_poll_cyc = cyc;
      end
      n_strobe++;
      last_strobe_cyc = cyc;
    end
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic push_table();
    exp_q.push_back(16'h90A5);
    exp_q.push_back(16'h913C);
    exp_q.push_back(16'h1200);
  endtask
  initial begin
    int s;
    logic found;
    rst_n = 1'b0; start = 1'b0; no_ack = 1'b0; force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {done, error, last_read, spi_strobe, spi_write, spi_address, spi_data_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", {done, error}, 0);
    // Table then three polls, third matches
    push_table();
    repeat (3) exp_q.push_back({1'b0, PADDR, 8'h00});
    poll_q = '{8'h00, 8'h00, 8'h01};
    n_poll = 0;
    pulse_start();
    @(negedge clk) chk("start_latency", spi_strobe, 1);
    for (int i = 0; i < 1000 && n_poll == 0; i++) @(negedge clk);
    chk("table_last_read", last_read, 8'h5A);
    for (int i = 0; i < 3000 && !(done || error); i++) @(negedge clk);
    chk("a_done", done, 1);
    chk("a_error", error, 0);
    chk("a_polls", n_poll, 3);
    chk("a_last_read", last_read, 8'h01);
    repeat (100) @(negedge clk);
    chk("a_queue_drained", exp_q.size(), 0);
    // Poll never matches: budget of MP reads then error
    push_table();
    repeat (MP) exp_q.push_back({1'b0, PADDR, 8'h00});
    repeat (MP) poll_q.push_back(8'h02);
    n_poll = 0;
    pulse_start();
    for (int i = 0; i < 3000 && !(done || error); i++) @(negedge clk);
    chk("b_error", error, 1);
    chk("b_done", done, 0);
    chk("b_polls", n_poll, MP);
    chk("b_last_read", last_read, 8'h02);
    s = n_strobe;
    repeat (200) @(negedge clk);
    chk("b_no_more_strobes", n_strobe, s);
    // No acknowledge: error exactly AT cycles after the strobe
    no_ack = 1'b1;
    exp_q.push_back(16'h90A5);
    pulse_start();
    for (int i = 0; i < 100 && !error; i++) @(negedge clk);
    chk("c_ack_timeout", cyc - last_strobe_cyc, AT);
    chk("c_flags", {done, error}, 2'b01);
    no_ack = 1'b0;
    // Busy held at start, then start mid-table is ignored
    force_busy = 1'b1;
    push_table();
    s = n_strobe;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("d_held_by_busy", n_strobe, s);
    force_busy = 1'b0;
    for (int i = 0; i < 20 && n_strobe == s; i++) @(negedge clk);
    chk("d_first_strobe", n_strobe, s + 1);
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (10) @(negedge clk);
    chk("d_start_ignored", n_strobe, s + 1);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = spi_strobe && spi_address == 7'h12;
    end
    chk("d_reached_read", found, 1);
    #1 rst_n = 1'b0;
    #1 chk("d_reset_strobe", spi_strobe, 0);
    chk("d_reset_flags", {done, error, last_read}, 0);
    // Reset during WAIT_DONE after a restart from entry 0
    @(negedge clk) rst_n = 1'b1;
    exp_q.push_back(16'h90A5);
    s = n_strobe;
    pulse_start();
    for (int i = 0; i < 20 && n_strobe == s; i++) @(negedge clk);
    chk("e_restart_strobe", n_strobe, s + 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("e_reset_fields", {spi_strobe, spi_write, spi_address, spi_data_in, done, error, last_read}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
